// File: rtl/div_clock_monitor.sv
// div_clock_monitor: measures a synchronized divided clock in fast cycles and tracks ratio lock
module div_clock_monitor #(
  parameter int DIV_RATIO   = 4,
  parameter int TOL         = 0,
  parameter int LOCK_COUNT  = 4,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             slow_clk_in,
  output logic             locked,
  output logic             lock_lost,
  output logic             timeout,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic [7:0]       err_count
);
  localparam int GW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] LO = CNT_W'(DIV_RATIO - TOL);
  localparam logic [CNT_W-1:0] HI = CNT_W'(DIV_RATIO + TOL);
  localparam logic [GW-1:0] LAST = GW'(LOCK_COUNT - 1);
  typedef enum logic [1:0] {IDLE, ARMED, CHECK, LOCKED} state_t;
  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [CNT_W-1:0]       r_cnt;
  logic [GW-1:0]          r_good;
  logic                   w_rise, w_live, w_good, w_tmo;
  logic [CNT_W-1:0]       w_cnt_inc;
  logic [7:0]             w_err_inc;
  always_comb begin
    w_rise    = r_sync[SYNC_STAGES-1] & ~r_prev;
    w_live    = (r_state == CHECK) || (r_state == LOCKED);
    w_good    = (r_cnt >= LO) && (r_cnt <= HI);
    w_tmo     = w_live && !w_rise && (r_cnt > HI);
    w_cnt_inc = &r_cnt ? r_cnt : r_cnt + 1'b1;
    w_err_inc = &err_count ? err_count : err_count + 8'd1;
  end
  // A rise always beats a pending timeout so the late period is still graded.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_sync       <= '0;
      r_prev       <= 1'b0;
      r_cnt        <= '0;
      r_good       <= '0;
      locked       <= 1'b0;
      lock_lost    <= 1'b0;
      timeout      <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      err_count    <= '0;
    end else begin
      r_sync       <= {r_sync[SYNC_STAGES-2:0], slow_clk_in};
      r_prev       <= r_sync[SYNC_STAGES-1];
      lock_lost    <= 1'b0;
      period_valid <= 1'b0;
      if (!enable) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_good  <= '0;
        locked  <= 1'b0;
        timeout <= 1'b0;
      end else begin
        case (r_state)
          IDLE: r_state <= ARMED;
          ARMED: begin
            r_cnt <= w_rise ? CNT_W'(1) : w_cnt_inc;
            if (w_rise) begin
              r_state <= CHECK;
              r_good  <= '0;
              timeout <= 1'b0;
            end
          end
          default: begin
            if (w_rise) begin
              r_cnt        <= CNT_W'(1);
              period       <= r_cnt;
              period_valid <= 1'b1;
              timeout      <= 1'b0;
              if (!w_good) begin
                r_state   <= CHECK;
                r_good    <= '0;
                err_count <= w_err_inc;
                lock_lost <= r_state == LOCKED;
                locked    <= 1'b0;
              end else if (r_state == CHECK) begin
                if (r_good == LAST) begin
                  r_state <= LOCKED;
                  locked  <= 1'b1;
                end else r_good <= r_good + 1'b1;
              end
            end else if (w_tmo) begin
              r_state   <= ARMED;
              r_cnt     <= w_cnt_inc;
              r_good    <= '0;
              err_count <= w_err_inc;
              timeout   <= 1'b1;
              lock_lost <= r_state == LOCKED;
              locked    <= 1'b0;
            end else r_cnt <= w_cnt_inc;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_div_clock_monitor.sv
// tb_div_clock_monitor: table-driven phases of slow-clock stimulus with a period scoreboard
module tb_div_clock_monitor;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       slow = 1'b0;
  logic       locked, lock_lost, timeout, period_valid;
  logic [7:0] period, err_count;
  int n_tests = 0, n_fail = 0, ll_cnt = 0, cyc = 0, last_rise = 0;
  bit push_ok = 0;
  int exp_q[$];
  typedef struct {
    bit en;
    int hi, lo, n;
    bit lk;
    int err;
    bit to;
    int ll;
    int per;
  } vec_t;
  vec_t tbl[12];
  div_clock_monitor dut (
    .clk(clk), .reset(reset), .enable(enable), .slow_clk_in(slow),
    .locked(locked), .lock_lost(lock_lost), .timeout(timeout),
    .period(period), .period_valid(period_valid), .err_count(err_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction
  always @(negedge clk) begin
    if (lock_lost) ll_cnt++;
    if (period_valid) begin
      if (exp_q.size() == 0) chk("unexpected period_valid", int'(period), -1);
      else chk("scoreboard period", int'(period), exp_q.pop_front());
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_period(int hi, int lo);
    if (push_ok) exp_q.push_back(cyc - last_rise);
    last_rise = cyc;
    push_ok = 1;
    slow = 1'b1;
    repeat (hi) tick();
    slow = 1'b0;
    repeat (lo) tick();
  endtask
  task automatic chk_state(string tag, int lk, int err, int to, int ll, int per);
    chk({tag, " locked"}, int'(locked), lk);
    chk({tag, " err_count"}, int'(err_count), err);
    chk({tag, " timeout"}, int'(timeout), to);
    chk({tag, " lock_lost pulses"}, ll_cnt, ll);
    chk({tag, " period"}, int'(period), per);
  endtask
  initial begin
    tbl[0]  = '{1, 2, 2, 5,   1, 0,   0, 0, 4};
    tbl[1]  = '{1, 3, 2, 1,   1, 0,   0, 0, 4};
    tbl[2]  = '{1, 2, 2, 1,   0, 1,   0, 1, 5};
    tbl[3]  = '{1, 2, 2, 3,   0, 1,   0, 1, 4};
    tbl[4]  = '{1, 2, 2, 1,   1, 1,   0, 1, 4};
    tbl[5]  = '{1, 0, 20, 1,  0, 2,   1, 2, 4};
    tbl[6]  = '{1, 2, 2, 1,   0, 2,   0, 2, 4};
    tbl[7]  = '{1, 2, 2, 4,   1, 2,   0, 2, 4};
    tbl[8]  = '{0, 0, 8, 1,   0, 2,   0, 2, 4};
    tbl[9]  = '{1, 2, 2, 5,   1, 2,   0, 2, 4};
    tbl[10] = '{1, 2, 1, 300, 0, 255, 0, 3, 3};
    tbl[11] = '{1, 2, 2, 5,   1, 255, 0, 3, 4};
    repeat (3) tick();
    chk_state("reset", 0, 0, 0, 0, 0);
    chk("reset lock_lost", int'(lock_lost), 0);
    chk("reset period_valid", int'(period_valid), 0);
    reset = 1'b0;
    tick();
    foreach (tbl[i]) begin
      enable = tbl[i].en;
      if (tbl[i].hi == 0) begin
        slow = 1'b0;
        push_ok = 0;
        repeat (tbl[i].lo) tick();
      end else repeat (tbl[i].n) run_period(tbl[i].hi, tbl[i].lo);
      chk_state($sformatf("e%0d", i), tbl[i].lk, tbl[i].err, tbl[i].to, tbl[i].ll, tbl[i].per);
    end
    // Reset in CHECK with two good periods banked must discard them.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push_ok = 0;
    repeat (3) run_period(2, 2);
    chk_state("mid_check", 0, 0, 0, 3, 4);
    reset = 1'b1;
    tick();
    chk_state("reset_in_check", 0, 0, 0, 3, 0);
    chk("reset_in_check period_valid", int'(period_valid), 0);
    chk("reset_in_check lock_lost", int'(lock_lost), 0);
    reset = 1'b0;
    push_ok = 0;
    repeat (4) run_period(2, 2);
    chk_state("after_reset_3good", 0, 0, 0, 3, 4);
    run_period(2, 2);
    chk_state("after_reset_relock", 1, 0, 0, 3, 4);
    repeat (5) tick();
    chk("scoreboard drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/div_clock_monitor.md
Name: div_clock_monitor

Overview:
- Receiving end of a divided-clock path. Samples a slow divided clock (e.g. a divide-by-4 `out_clk`) in the fast source clock domain.
- Measures each slow-clock period in fast cycles and declares lock once the ratio matches the expected division for a run of consecutive periods.
- Flags loss of lock or a stalled slow clock.
- Sits beside each clock divider as a health monitor for clock-gating and bring-up logic.

Parameters:
- DIV_RATIO, 4: expected fast-clock cycles per slow-clock period (>=2).
- TOL, 0: allowed +/- deviation in cycles for a period to count as good.
- LOCK_COUNT, 4: consecutive good periods required to assert locked (>=1).
- CNT_W, 8: width of period counter and period output; must hold DIV_RATIO+TOL+1.
- SYNC_STAGES, 2: synchronizer depth for slow_clk_in (>=2).

Ports:
- clk, input, 1: fast clock; all logic on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: monitor enable.
- slow_clk_in, input, 1: divided clock under test, asynchronous-safe.
- locked, output, 1: ratio lock status.
- lock_lost, output, 1: one-cycle pulse on loss of lock.
- timeout, output, 1: slow clock stalled.
- period, output, CNT_W: last measured period in clk cycles.
- period_valid, output, 1: one-cycle pulse when period updates.
- err_count, output, 8: saturating count of bad or timed-out periods.

Behaviour:
- Reset (reset=1 at a clk edge) clears everything: synchronizer flops, edge-detect flop, counters, state=IDLE, and all outputs to 0.
- Reset has priority over enable and slow_clk_in, including mid-CHECK or mid-LOCKED.
- Synchronizer:
  - slow_clk_in passes through SYNC_STAGES flops, then one prev flop.
  - rise = sync_out & ~prev.
  - An input edge produces rise SYNC_STAGES+1 cycles later. Falling edges are ignored.
- Cycle counter cnt:
  - Increments every cycle outside IDLE and saturates at all-ones.
  - On rise: measured = cnt, and cnt loads 1. The period is the number of clk cycles between successive rises.
- Outputs on rise:
  - period and period_valid update in the cycle after rise.
  - Not on the first rise after entering ARMED, since no start reference exists.
- Good period: DIV_RATIO-TOL <= measured <= DIV_RATIO+TOL.
- Timeout event: in CHECK or LOCKED, cnt exceeds DIV_RATIO+TOL with no rise.
- State machine:
  - IDLE: outputs locked=0 and timeout=0; cnt=0. Goes to ARMED when enable=1.
  - ARMED: waits for the first rise, then cnt=1 and goes to CHECK with good_cnt=0.
  - CHECK, good period: good_cnt+1. On reaching LOCK_COUNT, goes to LOCKED and locked=1 in the following cycle.
  - CHECK, bad period: good_cnt=0, err_count+1, stays in CHECK.
  - CHECK, timeout: goes to ARMED, good_cnt=0, err_count+1, timeout=1.
  - LOCKED, good period: stays in LOCKED.
  - LOCKED, bad period: goes to CHECK, locked=0, one-cycle lock_lost pulse, err_count+1, good_cnt=0.
  - LOCKED, timeout: goes to ARMED, locked=0, one-cycle lock_lost pulse, err_count+1, timeout=1.
- timeout clears on the next rise, on reset, or on enable=0.
- enable=0 in any state:
  - Next state is IDLE, locked=0, cnt=0, no lock_lost pulse.
  - err_count and period hold their values.
- err_count saturates at 255 and is cleared only by reset.
- Simultaneous events:
  - Rise and a timeout condition in the same cycle: the rise wins, and the period is evaluated as good/bad.
  - enable falling at the same time as a bad period: the enable drop wins, with no error and no pulse.

Test Plan:
- Slow clock as a 2-high/2-low square wave, DIV_RATIO=4, TOL=0, LOCK_COUNT=4 → period=4 with period_valid on each rise after the first; locked rises after the 4th good period; err_count=0.
- While locked, stretch one period to 5 cycles → one lock_lost pulse, locked=0, err_count=1, period=5; relocks after 4 further good periods.
- While locked, hold slow_clk_in low → timeout when cnt passes 4:
  - lock_lost pulse, locked=0, timeout=1, err_count+1.
  - Restarting the clock clears timeout on the first rise, then relocks after 1+4 rises.
- Continuous 3-cycle periods for 300 periods → locked stays 0 and err_count saturates at 255.
- Assert reset mid-CHECK after 2 good periods → all outputs 0 the next cycle; lock requires a fresh ARMED→CHECK sequence.
- Drop enable while locked → locked=0 and no lock_lost pulse; err_count and period hold; re-enable relocks after 1+4 rises.
